// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 7-segment digit scanner.
// Walks the digits with an IDLE / BLANK / SHOW sequence: every digit gets a
// short all-off blank (anti-ghosting) before its SHOW window. Per-digit value
// and enable registers are written through a simple strobe port. All outputs
// are registered, so they trail the internal state by one cycle.
// Optional blink feature: define SEG_SCAN_BLINK_EN to count frames and blank
// the masked digits during the off half of each blink period. Without it the
// blk_wr/blk_mask ports are present but ignored.
module seg_scan_ctrl #(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 1000,
  parameter int BLANK_CYC = 16,
  parameter int BLINK_DIV = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_en,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [2:0]        wr_data,
  input  logic              wr_on,
  input  logic              blk_wr,
  input  logic [DIGITS-1:0] blk_mask,
  output logic [DIGITS-1:0] dig_sel,
  output logic [2:0]        dec_data,
  output logic              dec_en,
  output logic              frame_done
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [2:0]        idx, idx_nx;
  logic              frame_end;

  logic [2:0]        val [DIGITS];
  logic [DIGITS-1:0] on;
  logic [DIGITS-1:0] blink_kill;

  logic [DIGITS-1:0] sel_p0;
  logic [2:0]        data_p0;
  logic              en_p0;
  logic [2:0]        cur_val;
  logic              cur_on;
  logic              cur_kill;

  // State register: scan state, per-window cycle counter and digit index
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  // Next-state logic: dropping scan_en parks the scanner in IDLE at digit 0
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    frame_end = 1'b0;
    if (!scan_en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = BLANK;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nx = SHOW;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state_nx = BLANK;
            cnt_nx   = '0;
            if (idx == IDX_LAST) begin
              idx_nx    = '0;
              frame_end = 1'b1;
            end else begin
              idx_nx = idx + 3'd1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Digit value/enable registers; addresses past the last digit match nothing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) val[i] <= '0;
      on <= '1;
    end else if (wr_en) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_addr == 3'(i)) begin
          val[i] <= wr_data;
          on[i]  <= wr_on;
        end
      end
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

  logic [DIGITS-1:0] mask;
  logic              phase_on;
  logic [FW-1:0]     fcnt;

  // Blink mask load and frame counter that flips the blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      mask     <= '0;
      phase_on <= 1'b1;
      fcnt     <= '0;
    end else begin
      if (blk_wr) mask <= blk_mask;
      if (frame_end) begin
        if (fcnt == FRM_LAST) begin
          fcnt     <= '0;
          phase_on <= ~phase_on;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end
    end
  end

  assign blink_kill = phase_on ? '0 : mask;
`else
  logic blink_unused;
  assign blink_unused = ^{blk_wr, blk_mask};
  assign blink_kill   = '0;
`endif

  // Output decode: only SHOW drives a digit strobe; anything else is blanked
  always_comb begin
    cur_val  = '0;
    cur_on   = 1'b0;
    cur_kill = 1'b0;
    sel_p0   = '1;
    data_p0  = '0;
    en_p0    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_val  = val[i];
        cur_on   = on[i];
        cur_kill = blink_kill[i];
      end
    end
    if (scan_en && state == SHOW) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx == 3'(i)) sel_p0[i] = 1'b0;
      end
      data_p0 = cur_val;
      en_p0   = cur_on & ~cur_kill;
    end
  end

  // ---- stage boundary: registered outputs ----
  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_sel    <= '1;
      dec_data   <= '0;
      dec_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dig_sel    <= sel_p0;
      dec_data   <= data_p0;
      dec_en     <= en_p0;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: an 8-digit instance runs the main scenario and a
// 6-digit instance checks out-of-range write addresses. Expected outputs are
// queued with the clock edge they belong to; a monitor compares on negedge.
module tb_seg_scan_ctrl;

`ifdef SEG_SCAN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst;
  logic       scan_en, wr_en, wr_on, blk_wr;
  logic [2:0] wr_addr, wr_data;
  logic [7:0] blk_mask;
  logic [7:0] dig_sel;
  logic [2:0] dec_data;
  logic       dec_en, frame_done;

  logic       scan_en6, wr_en6, wr_on6, blk_wr6;
  logic [2:0] wr_addr6, wr_data6;
  logic [5:0] blk_mask6;
  logic [5:0] dig_sel6;
  logic [2:0] dec_data6;
  logic       dec_en6, frame_done6;

  seg_scan_ctrl #(.DIGITS(8), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_on(wr_on), .blk_wr(blk_wr), .blk_mask(blk_mask),
    .dig_sel(dig_sel), .dec_data(dec_data), .dec_en(dec_en), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.DIGITS(6), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(2)) dut6 (
    .clk(clk), .rst(rst), .scan_en(scan_en6), .wr_en(wr_en6), .wr_addr(wr_addr6),
    .wr_data(wr_data6), .wr_on(wr_on6), .blk_wr(blk_wr6), .blk_mask(blk_mask6),
    .dig_sel(dig_sel6), .dec_data(dec_data6), .dec_en(dec_en6), .frame_done(frame_done6)
  );

  typedef struct {
    int         cyc;
    logic [7:0] sel;
    logic [2:0] data;
    logic       en;
    logic       fd;
  } exp_t;

  exp_t q8[$];
  exp_t q6[$];
  exp_t x8, x6;
  int   nvec = 0;
  int   nfail = 0;
  bit   done = 1'b0;

  task automatic push_idle(input bit six, input int e);
    exp_t x;
    x = '{e, 8'hFF, 3'd0, 1'b0, 1'b0};
    if (six) q6.push_back(x);
    else q8.push_back(x);
  endtask

  // One 8-digit frame whose digit-0 blank lands on edge b; edges past 'last'
  // are not queued. Before edge old_until the digit values come from old_vals.
  task automatic push_frame8(input int b, input int last, input logic [23:0] vals,
                             input logic [23:0] old_vals, input int old_until,
                             input logic [7:0] ens);
    exp_t x;
    int   e, d;
    logic [7:0] one;
    for (int k = 0; k < 40; k++) begin
      e = b + k;
      if (e > last) break;
      d = k / 5;
      if (k % 5 == 0) begin
        x = '{e, 8'hFF, 3'd0, 1'b0, 1'b0};
      end else begin
        one    = 8'd1 << d;
        x.cyc  = e;
        x.sel  = ~one;
        x.data = (e < old_until) ? old_vals[3*d +: 3] : vals[3*d +: 3];
        x.en   = ens[d];
        x.fd   = (k == 39);
      end
      q8.push_back(x);
    end
  endtask

  // One 6-digit frame, all digits at reset contents (value 0, enabled)
  task automatic push_frame6(input int b);
    exp_t x;
    int   d;
    logic [5:0] one;
    for (int k = 0; k < 30; k++) begin
      d = k / 5;
      if (k % 5 == 0) begin
        x = '{b + k, 8'hFF, 3'd0, 1'b0, 1'b0};
      end else begin
        one    = 6'd1 << d;
        x.cyc  = b + k;
        x.sel  = {2'b11, ~one};
        x.data = 3'd0;
        x.en   = 1'b1;
        x.fd   = (k == 29);
      end
      q6.push_back(x);
    end
  endtask

  task automatic at_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop every expectation due at this edge and compare
  always @(negedge clk) begin
    while (q8.size() > 0 && q8[0].cyc <= cyc) begin
      x8 = q8.pop_front();
      nvec++;
      if (x8.cyc != cyc || dig_sel !== x8.sel || dec_data !== x8.data ||
          dec_en !== x8.en || frame_done !== x8.fd) begin
        nfail++;
        $display("FAIL dut8 edge %0d: got sel=%h data=%0d en=%b fd=%b, want sel=%h data=%0d en=%b fd=%b (due edge %0d)",
                 cyc, dig_sel, dec_data, dec_en, frame_done, x8.sel, x8.data, x8.en, x8.fd, x8.cyc);
      end
    end
    while (q6.size() > 0 && q6[0].cyc <= cyc) begin
      x6 = q6.pop_front();
      nvec++;
      if (x6.cyc != cyc || {2'b11, dig_sel6} !== x6.sel || dec_data6 !== x6.data ||
          dec_en6 !== x6.en || frame_done6 !== x6.fd) begin
        nfail++;
        $display("FAIL dut6 edge %0d: got sel=%h data=%0d en=%b fd=%b, want sel=%h data=%0d en=%b fd=%b (due edge %0d)",
                 cyc, {2'b11, dig_sel6}, dec_data6, dec_en6, frame_done6, x6.sel, x6.data, x6.en, x6.fd, x6.cyc);
      end
    end
    if (done) begin
      nvec++;
      if (q8.size() != 0 || q6.size() != 0) begin
        nfail++;
        $display("FAIL leftover: got %0d/%0d unchecked entries, want 0/0", q8.size(), q6.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
    end
  end

  localparam logic [23:0] V0 = {3'd0, 3'd2, 3'd0, 3'd0, 3'd5, 3'd1, 3'd0, 3'd0};
  localparam logic [23:0] V1 = {3'd0, 3'd2, 3'd0, 3'd0, 3'd5, 3'd4, 3'd0, 3'd0};
  localparam logic [7:0]  EN_ON  = 8'b1011_1111;
  localparam logic [7:0]  EN_BLK = BLINK ? 8'b1011_1110 : 8'b1011_1111;

  initial begin
    rst = 1'b1; scan_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_on = 1'b0;
    blk_wr = 1'b0; blk_mask = '0;
    scan_en6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = '0; wr_data6 = '0; wr_on6 = 1'b0;
    blk_wr6 = 1'b0; blk_mask6 = '0;

    for (int e = 1; e <= 5; e++) begin
      push_idle(1'b0, e);
      push_idle(1'b1, e);
    end
    at_edge(5);

    // Scan starts; writes digit 3 = 5 on, mask digit 0 for blinking
    rst = 1'b0; scan_en = 1'b1; blk_wr = 1'b1; blk_mask = 8'h01;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 3'd5; wr_on = 1'b1;
    scan_en6 = 1'b1; wr_en6 = 1'b1; wr_addr6 = 3'd7; wr_data6 = 3'd7; wr_on6 = 1'b0;
    push_idle(1'b0, 6);
    push_frame8(7,   46,  V0, V0, 0,  EN_ON);
    push_frame8(47,  86,  V1, V0, 60, EN_ON);
    push_frame8(87,  126, V1, V1, 0,  EN_BLK);
    push_frame8(127, 166, V1, V1, 0,  EN_BLK);
    push_frame8(167, 193, V1, V1, 0,  EN_ON);
    for (int e = 194; e <= 196; e++) push_idle(1'b0, e);
    push_frame8(197, 209, V1, V1, 0,  EN_ON);
    for (int e = 210; e <= 212; e++) push_idle(1'b0, e);
    push_frame8(213, 252, 24'd0, 24'd0, 0, 8'hFF);
    push_idle(1'b1, 6);
    push_frame6(7);
    push_frame6(37);

    at_edge(6);
    blk_wr = 1'b0; wr_addr = 3'd6; wr_data = 3'd2; wr_on = 1'b0;
    wr_addr6 = 3'd6; wr_data6 = 3'd6; wr_on6 = 1'b0;
    at_edge(7);
    wr_addr = 3'd2; wr_data = 3'd1; wr_on = 1'b1;
    wr_en6 = 1'b0;
    at_edge(8);
    wr_en = 1'b0;

    // Rewrite digit 2 in the middle of its frame-1 window
    at_edge(58);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 3'd4; wr_on = 1'b1;
    at_edge(59);
    wr_en = 1'b0;

    at_edge(66);
    scan_en6 = 1'b0;

    // Drop scan_en during digit 5, then restart
    at_edge(193);
    scan_en = 1'b0;
    at_edge(195);
    scan_en = 1'b1;

    // Reset mid-frame with a competing write
    at_edge(209);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 3'd7; wr_on = 1'b0;
    at_edge(211);
    rst = 1'b0; wr_en = 1'b0;

    at_edge(255);
    done = 1'b1;
    at_edge(300);
    $display("FAIL monitor: got no summary by edge %0d, want summary at edge 255", cyc);
    $fatal(1, "monitor did not finish");
  end

endmodule
